// File: rtl/step_gen_pkg.sv
// Shared constants and FSM encoding for the step pulse generator.
package step_gen_pkg;

  localparam int unsigned DEF_CNT_WIDTH    = 32;
  localparam int unsigned DEF_PULSE_CYCLES = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_e;

endpackage

// File: rtl/step_gen_if.sv
// Command/status bundle between a motion controller and one step_gen channel.
interface step_gen_if #(
  parameter int unsigned CNT_WIDTH = 32
);
  import step_gen_pkg::*;

  // start_in is a request sampled only while r_busy_out is low (IDLE acts as
  // "ready"); a request seen while busy is dropped, not queued.
  logic                 start_in;
  logic                 abort_in;
  logic                 dir_in;
  logic [CNT_WIDTH-1:0] period_in;
  logic [CNT_WIDTH-1:0] steps_in;
  logic                 r_step_out;
  logic                 r_dir_out;
  logic                 r_busy_out;
  logic                 r_done_out;
  logic [CNT_WIDTH-1:0] r_remaining_out;
  state_e               r_state_out;

  modport master (
    output start_in, abort_in, dir_in, period_in, steps_in,
    input  r_step_out, r_dir_out, r_busy_out, r_done_out, r_remaining_out, r_state_out
  );

  modport slave (
    input  start_in, abort_in, dir_in, period_in, steps_in,
    output r_step_out, r_dir_out, r_busy_out, r_done_out, r_remaining_out, r_state_out
  );

endinterface

// File: rtl/step_gen_down_counter.sv
// Loadable down counter that saturates at zero; times both pulse phases.
module step_gen_down_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (en_i && (count_q != '0)) begin
      count_q <= count_q - WIDTH'(1);
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/step_gen.sv
// Step/direction pulse generator: emits a fixed number of fixed-width pulses
// at a programmable period, with abort and a one-cycle completion pulse.
module step_gen
  import step_gen_pkg::*;
#(
  parameter int unsigned CNT_WIDTH    = DEF_CNT_WIDTH,
  parameter int unsigned PULSE_CYCLES = DEF_PULSE_CYCLES
) (
  input  logic       clk_in,
  input  logic       reset_in,
  step_gen_if.slave  bus
);

  localparam logic [CNT_WIDTH-1:0] ONE        = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] PULSE_W    = CNT_WIDTH'(PULSE_CYCLES);
  localparam logic [CNT_WIDTH-1:0] MIN_PERIOD = CNT_WIDTH'(PULSE_CYCLES + 1);
  localparam logic [CNT_WIDTH-1:0] HIGH_LOAD  = CNT_WIDTH'(PULSE_CYCLES - 1);

  state_e               state_q;
  logic                 step_q, dir_q, busy_q, done_q;
  logic [CNT_WIDTH-1:0] remaining_q;
  logic [CNT_WIDTH-1:0] low_load_q;

  logic                 accept;
  logic [CNT_WIDTH-1:0] eff_period, low_load_d;
  logic                 cnt_load, cnt_en, cnt_zero;
  logic [CNT_WIDTH-1:0] cnt_val;

  assign accept = (state_q == ST_IDLE) && bus.start_in && !bus.abort_in;

  // Counter is loaded with (length - 1) so zero marks the last cycle of a phase.
  always_comb begin
    eff_period = (bus.period_in < MIN_PERIOD) ? MIN_PERIOD : bus.period_in;
    low_load_d = eff_period - PULSE_W - ONE;
  end

  always_comb begin
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    cnt_val  = '0;
    case (state_q)
      ST_IDLE: begin
        if (accept && (bus.steps_in != '0)) begin
          cnt_load = 1'b1;
          cnt_val  = HIGH_LOAD;
        end
      end
      ST_HIGH: begin
        if (bus.abort_in) begin
          cnt_load = 1'b1;
        end else if (cnt_zero) begin
          cnt_load = 1'b1;
          cnt_val  = low_load_q;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_LOW: begin
        if (bus.abort_in) begin
          cnt_load = 1'b1;
        end else if (cnt_zero) begin
          cnt_load = 1'b1;
          cnt_val  = (remaining_q != '0) ? HIGH_LOAD : '0;
        end else begin
          cnt_en = 1'b1;
        end
      end
      default: cnt_load = 1'b1;
    endcase
  end

  step_gen_down_counter #(.WIDTH(CNT_WIDTH)) u_phase_cnt (
    .clk_i      (clk_in),
    .rst_i      (reset_in),
    .load_i     (cnt_load),
    .en_i       (cnt_en),
    .load_val_i (cnt_val),
    .zero_o     (cnt_zero)
  );

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q     <= ST_IDLE;
      step_q      <= 1'b0;
      dir_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      remaining_q <= '0;
      low_load_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (bus.steps_in == '0) begin
              done_q <= 1'b1;
            end else begin
              state_q     <= ST_HIGH;
              step_q      <= 1'b1;
              busy_q      <= 1'b1;
              dir_q       <= bus.dir_in;
              remaining_q <= bus.steps_in - ONE;
              low_load_q  <= low_load_d;
            end
          end
        end
        ST_HIGH: begin
          if (bus.abort_in) begin
            state_q     <= ST_IDLE;
            step_q      <= 1'b0;
            busy_q      <= 1'b0;
            remaining_q <= '0;
          end else if (cnt_zero) begin
            state_q <= ST_LOW;
            step_q  <= 1'b0;
          end
        end
        ST_LOW: begin
          if (bus.abort_in) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            remaining_q <= '0;
          end else if (cnt_zero) begin
            if (remaining_q != '0) begin
              state_q     <= ST_HIGH;
              step_q      <= 1'b1;
              remaining_q <= remaining_q - ONE;
            end else begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          step_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.r_step_out      = step_q;
  assign bus.r_dir_out       = dir_q;
  assign bus.r_busy_out      = busy_q;
  assign bus.r_done_out      = done_q;
  assign bus.r_remaining_out = remaining_q;
  assign bus.r_state_out     = state_q;

endmodule

// File: tb/tb_step_gen.sv
// Directed bench for step_gen with PULSE_CYCLES=4 and hand-computed pulse timelines.
module tb_step_gen;
  import step_gen_pkg::*;

  localparam int W = 32;

  logic clk_in = 1'b0;
  logic reset_in;

  step_gen_if #(.CNT_WIDTH(W)) bus ();

  step_gen #(.CNT_WIDTH(W), .PULSE_CYCLES(4)) dut (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .bus      (bus)
  );

  // clock / reset
  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // observations gathered by run_move; sample k is the k-th negedge after the start edge
  int   rises[$];
  logic [W-1:0] exp_q[$];
  int   high_cycles, done_cnt, done_at, last_fall, busy_seen, dir_changes;
  logic [W-1:0] rem_first;
  logic snap_step, snap_busy, snap_done, snap_dir;
  logic [W-1:0] snap_rem;
  logic [1:0]   snap_state;
  int   abort_at = -1, restart_at = -1, reset_at = -1, snap_at = -1;

  task automatic run_move(input logic dir, input logic [W-1:0] period,
                          input logic [W-1:0] steps, input int n);
    logic prev_step, prev_dir;
    rises.delete();
    high_cycles = 0; done_cnt = 0; done_at = -1; last_fall = -1;
    busy_seen = 0; dir_changes = 0; rem_first = '0;
    bus.dir_in = dir; bus.period_in = period; bus.steps_in = steps;
    bus.start_in = 1'b1;
    bus.abort_in = (abort_at == 0);
    prev_step = bus.r_step_out;
    prev_dir  = bus.r_dir_out;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk_in);
      bus.start_in = (k == restart_at);
      if (k == restart_at) begin
        bus.dir_in = ~dir; bus.period_in = 5; bus.steps_in = 9;
      end
      bus.abort_in = (k == abort_at);
      reset_in     = (k == reset_at);
      if (bus.r_step_out && !prev_step) rises.push_back(k);
      if (!bus.r_step_out && prev_step) last_fall = k;
      if (bus.r_step_out) high_cycles++;
      if (bus.r_done_out) begin done_cnt++; done_at = k; end
      if (bus.r_busy_out) busy_seen = 1;
      if (k > 1 && bus.r_dir_out != prev_dir) dir_changes++;
      if (k == 1) rem_first = bus.r_remaining_out;
      if (k == snap_at) begin
        snap_step = bus.r_step_out; snap_busy = bus.r_busy_out;
        snap_done = bus.r_done_out; snap_dir = bus.r_dir_out;
        snap_rem = bus.r_remaining_out; snap_state = bus.r_state_out;
      end
      prev_step = bus.r_step_out;
      prev_dir  = bus.r_dir_out;
    end
    bus.start_in = 1'b0; bus.abort_in = 1'b0; reset_in = 1'b0;
    abort_at = -1; restart_at = -1; reset_at = -1; snap_at = -1;
  endtask

  // scoreboard: expected rising-edge sample indices against observed ones
  task automatic check_rises(input string tag, input int first, input int gap, input int count);
    exp_q.delete();
    for (int i = 0; i < count; i++) exp_q.push_back(W'(first + i * gap));
    check({tag, "_rise_count"}, rises.size(), count);
    for (int i = 0; i < count && i < rises.size(); i++) begin
      check({tag, "_rise_at"}, rises[i], exp_q.pop_front());
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  initial begin
    reset_in = 1'b1;
    bus.start_in = 1'b0; bus.abort_in = 1'b0; bus.dir_in = 1'b0;
    bus.period_in = '0; bus.steps_in = '0;
    idle(3);
    check("rst_step", bus.r_step_out, 0);
    check("rst_dir", bus.r_dir_out, 0);
    check("rst_busy", bus.r_busy_out, 0);
    check("rst_done", bus.r_done_out, 0);
    check("rst_rem", bus.r_remaining_out, 0);
    check("rst_state", bus.r_state_out, ST_IDLE);
    reset_in = 1'b0;
    idle(2);

    // 3 steps, period 10: highs at 1-4, 11-14, 21-24; done 6 after last fall
    run_move(1'b1, 10, 3, 34);
    check_rises("basic", 1, 10, 3);
    check("basic_high", high_cycles, 12);
    check("basic_rem_first", rem_first, 2);
    check("basic_done_cnt", done_cnt, 1);
    check("basic_done_at", done_at, 31);
    check("basic_done_gap", done_at - last_fall, 6);
    check("basic_dir", bus.r_dir_out, 1);
    check("basic_busy_end", bus.r_busy_out, 0);
    idle(2);

    // zero steps: only a done pulse right after the sampling edge
    run_move(1'b0, 10, 0, 8);
    check("zero_rises", rises.size(), 0);
    check("zero_busy", busy_seen, 0);
    check("zero_done_cnt", done_cnt, 1);
    check("zero_done_at", done_at, 1);
    idle(2);

    // period 2 clamps to 5
    run_move(1'b0, 2, 2, 14);
    check_rises("clamp", 1, 5, 2);
    check("clamp_high", high_cycles, 8);
    check("clamp_done_at", done_at, 11);
    check("clamp_dir", bus.r_dir_out, 0);
    idle(2);

    // period exactly PULSE_CYCLES+1, single step
    run_move(1'b1, 5, 1, 8);
    check_rises("minper", 1, 5, 1);
    check("minper_high", high_cycles, 4);
    check("minper_done_at", done_at, 6);
    idle(2);

    // abort during the second pulse (high at 9-12), driven at sample 10
    abort_at = 10; snap_at = 11;
    run_move(1'b0, 8, 5, 20);
    check_rises("abort", 1, 8, 2);
    check("abort_high", high_cycles, 6);
    check("abort_rem_first", rem_first, 4);
    check("abort_done_cnt", done_cnt, 0);
    check("abort_snap_step", snap_step, 0);
    check("abort_snap_busy", snap_busy, 0);
    check("abort_snap_rem", snap_rem, 0);
    idle(2);

    // abort together with start in IDLE: nothing starts, direction not latched
    abort_at = 0;
    run_move(1'b1, 10, 3, 6);
    check("abst_rises", rises.size(), 0);
    check("abst_busy", busy_seen, 0);
    check("abst_done", done_cnt, 0);
    check("abst_dir", bus.r_dir_out, 0);
    idle(2);

    // restart with toggled direction mid-move is ignored
    restart_at = 8;
    run_move(1'b1, 6, 3, 22);
    check_rises("restart", 1, 6, 3);
    check("restart_high", high_cycles, 12);
    check("restart_done_at", done_at, 19);
    check("restart_dir_chg", dir_changes, 0);
    check("restart_dir", bus.r_dir_out, 1);
    idle(2);

    // reset in LOW of a 4-step move, then a full move
    reset_at = 6; snap_at = 7;
    run_move(1'b1, 10, 4, 10);
    check_rises("rstmid", 1, 10, 1);
    check("rstmid_step", snap_step, 0);
    check("rstmid_busy", snap_busy, 0);
    check("rstmid_done", snap_done, 0);
    check("rstmid_dir", snap_dir, 0);
    check("rstmid_rem", snap_rem, 0);
    check("rstmid_state", snap_state, ST_IDLE);
    idle(2);
    run_move(1'b1, 10, 4, 44);
    check_rises("after_rst", 1, 10, 4);
    check("after_rst_done_cnt", done_cnt, 1);
    check("after_rst_done_at", done_at, 41);
    check("after_rst_high", high_cycles, 16);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
